// File: rtl/seq_pkg.sv
// Shared opcode values, sequencer state encoding and decode helpers for seq_fetch_exec.
package seq_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_JUMP  = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_HALT,
        ST_STEP_WAIT
    } state_t;

    function automatic logic is_mem_op(input logic [1:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_STORE);
    endfunction

    function automatic logic is_write_op(input logic [1:0] opcode);
        return opcode == OP_STORE;
    endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter: asynchronous active-low reset to START_ADDR, load (jump/restart) beats increment.
module seq_pc #(
    parameter int ADDR_W     = 4,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= ADDR_W'(START_ADDR);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/seq_fetch_exec.sv
// Fetch/execute sequencer driving one req/ack memory port (LOAD/STORE/JUMP/HALT).
// Optional single-step gate after each instruction when SEQ_STEP_MODE_EN is defined.
module seq_fetch_exec
    import seq_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] acc,
    output logic              busy,
    output logic              halted
`ifdef SEQ_STEP_MODE_EN
    ,
    input  logic              step
`endif
);

    generate
        if (DATA_W < ADDR_W + 2) begin : g_width_check
            $error("seq_fetch_exec: DATA_W must be at least ADDR_W+2");
        end
    endgenerate

`ifdef SEQ_STEP_MODE_EN
    localparam state_t EXEC_DONE = ST_STEP_WAIT;
`else
    localparam state_t EXEC_DONE = ST_FETCH;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_cur;

    logic [1:0]        opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = ir_q[DATA_W-1 -: 2];
    assign operand = ir_q[ADDR_W-1:0];

    seq_pc #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc_cur)
    );

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_load     = 1'b0;
        pc_load_val = pc_cur;
        pc_inc      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_cur;
                end
            end
            ST_FETCH: begin
                if (req_q) begin
                    if (mem_ack) begin
                        ir_d    = mem_rdata;
                        pc_inc  = 1'b1;
                        req_d   = 1'b0;
                        state_d = ST_EXEC;
                    end
                end else if (!run) begin
                    // Instruction boundary: the only place run=0 is honoured.
                    state_d = ST_IDLE;
                end else begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = pc_cur;
                end
            end
            ST_EXEC: begin
                if (is_mem_op(opcode)) begin
                    if (!req_q) begin
                        req_d   = 1'b1;
                        we_d    = is_write_op(opcode);
                        addr_d  = operand;
                        wdata_d = acc_q;
                    end else if (mem_ack) begin
                        if (!is_write_op(opcode)) begin
                            acc_d = mem_rdata;
                        end
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        state_d = EXEC_DONE;
                    end
                end else if (opcode == OP_JUMP) begin
                    pc_load     = 1'b1;
                    pc_load_val = operand;
                    state_d     = EXEC_DONE;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!run) begin
                    pc_load     = 1'b1;
                    pc_load_val = ADDR_W'(START_ADDR);
                    state_d     = ST_IDLE;
                end
            end
`ifdef SEQ_STEP_MODE_EN
            ST_STEP_WAIT: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase

        busy_d   = (state_d == ST_FETCH) || (state_d == ST_EXEC) || (state_d == ST_STEP_WAIT);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            acc_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            acc_q    <= acc_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_cur;
    assign ir        = ir_q;
    assign acc       = acc_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule
